dmem_arbiter: RTL and testbench

Two-port arbiter that shares the single-port data memory of the 16-bit RISC core between the CPU load/store path (port A) and a debug/loader master (port B). Each cycle it grants at most one request, drives the memory, and returns read data one cycle later. Contention is resolved by round-robin. Port B may optionally lock the memory for bounded bursts. The CPU stalls on `a_stall` while its request is not granted.

---
 rtl/dmem_arbiter.sv | 167 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares the single-port data memory of the 16-bit RISC core between the CPU
// load/store path (port A) and a debug/loader master (port B). At most one
// request is granted per cycle, combinationally, by round-robin. The winner
// drives the memory. Read data returns one cycle after the grant.
//
// Optional feature macro: DMEM_ARB_LOCK_EN
//   defined   : b_lock lets port B keep the memory for up to MAX_LOCK
//               consecutive grants while A waits (adds LOCK_B and lock_cnt).
//   undefined : b_lock is ignored; pure A/B round-robin.
//
// Ports
//   clk, reset                    : clock, synchronous active-high reset
//   a_req/a_we/a_addr/a_wdata     : CPU request
//   a_gnt/a_stall                 : CPU grant, stall (= a_req & ~a_gnt)
//   a_rvalid/a_rdata              : CPU read response (rdata 0 when invalid)
//   b_req/b_we/b_addr/b_wdata     : loader request
//   b_lock                        : loader ownership hold request
//   b_gnt/b_rvalid/b_rdata        : loader grant and read response
//   mem_en/mem_we/mem_addr/mem_wdata : memory strobe, zeroed when idle
//   mem_rdata                     : synchronous-read memory data
module dmem_arbiter #(
  parameter int ADDR_W   = 3,
  parameter int DATA_W   = 16,
  parameter int MAX_LOCK = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_stall,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  input  logic              b_lock,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

`ifdef DMEM_ARB_LOCK_EN
  typedef enum logic [1:0] {LAST_A = 2'd0, LAST_B = 2'd1, LOCK_B = 2'd2} state_e;

  localparam logic [3:0] MAX_LOCK_C = 4'(MAX_LOCK);

  logic [3:0] lock_cnt_q, lock_cnt_d;

  // Saturating lock-length counter increment.
  function automatic logic [3:0] sat_inc(input logic [3:0] c);
    return (c < MAX_LOCK_C) ? c + 4'd1 : MAX_LOCK_C;
  endfunction
`else
  typedef enum logic {LAST_A = 1'b0, LAST_B = 1'b1} state_e;

  // b_lock and MAX_LOCK have no effect in this build.
  logic unused_lock;
  assign unused_lock = b_lock ^ (MAX_LOCK == 0);
`endif

  state_e state_q, state_d;
  logic   a_pend_q, b_pend_q;
  logic   a_win, b_win;

  // Winner selection: a lone requester always wins; on contention the port
  // that did not win last time goes first, unless B is inside a lock burst.
  always_comb begin
    a_win = 1'b0;
    b_win = 1'b0;
    if (a_req && b_req) begin
      case (state_q)
        LAST_A: b_win = 1'b1;
`ifdef DMEM_ARB_LOCK_EN
        LOCK_B: begin
          if (b_lock && (lock_cnt_q < MAX_LOCK_C)) b_win = 1'b1;
          else                                       a_win = 1'b1;
        end
`endif
        default: a_win = 1'b1;
      endcase
    end else begin
      a_win = a_req;
      b_win = b_req;
    end
  end

  assign a_gnt   = a_win & ~reset;
  assign b_gnt   = b_win & ~reset;
  assign a_stall = a_req & ~a_gnt & ~reset;

  always_comb begin
    state_d = state_q;
`ifdef DMEM_ARB_LOCK_EN
    lock_cnt_d = lock_cnt_q;
    if (a_gnt) begin
      state_d    = LAST_A;
      lock_cnt_d = 4'd0;
    end else if (b_gnt && b_lock) begin
      state_d    = LOCK_B;
      lock_cnt_d = (state_q == LOCK_B) ? sat_inc(lock_cnt_q) : 4'd1;
    end else if (b_gnt) begin
      state_d    = LAST_B;
      lock_cnt_d = 4'd0;
    end else if (state_q == LOCK_B) begin
      // No grant means B dropped its request; the lock ends.
      state_d = LAST_B;
    end
`else
    if (a_gnt)      state_d = LAST_A;
    else if (b_gnt) state_d = LAST_B;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= LAST_B;
      a_pend_q <= 1'b0;
      b_pend_q <= 1'b0;
`ifdef DMEM_ARB_LOCK_EN
      lock_cnt_q <= 4'd0;
`endif
    end else begin
      state_q  <= state_d;
      a_pend_q <= a_gnt & ~a_we;
      b_pend_q <= b_gnt & ~b_we;
`ifdef DMEM_ARB_LOCK_EN
      lock_cnt_q <= lock_cnt_d;
`endif
    end
  end

  // Memory drive: winner's request, all zero when idle.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (a_gnt) begin
      mem_we    = a_we;
      mem_addr  = a_addr;
      mem_wdata = a_wdata;
    end else if (b_gnt) begin
      mem_we    = b_we;
      mem_addr  = b_addr;
      mem_wdata = b_wdata;
    end
  end

  assign mem_en = a_gnt | b_gnt;

  // Responses are suppressed while reset is high so an in-flight read is
  // dropped rather than delivered during the reset cycle.
  assign a_rvalid = a_pend_q & ~reset;
  assign b_rvalid = b_pend_q & ~reset;
  assign a_rdata  = a_rvalid ? mem_rdata : '0;
  assign b_rdata  = b_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: drives scenario tasks cycle by cycle, checks
// grants and memory strobes inline, and matches read responses against a
// queue of expected data built from a reference copy of memory contents.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0, b_lock = 1'b0;
  logic [2:0]  a_addr = 3'd0, b_addr = 3'd0;
  logic [15:0] a_wdata = 16'h0, b_wdata = 16'h0;
  logic        a_gnt, a_stall, a_rvalid, b_gnt, b_rvalid;
  logic [15:0] a_rdata, b_rdata;
  logic        mem_en, mem_we;
  logic [2:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = 16'h0;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    logic [15:0] data;
    int          due;
  } rsp_t;

  rsp_t aq[$];
  rsp_t bq[$];
  rsp_t a_e, b_e;

  logic [15:0] ram [8] = '{16'hA000, 16'hA001, 16'hA002, 16'hA003,
                           16'hA004, 16'h1234, 16'hA006, 16'hA007};
  logic [15:0] ref_mem [8] = '{16'hA000, 16'hA001, 16'hA002, 16'hA003,
                               16'hA004, 16'h1234, 16'hA006, 16'hA007};

  dmem_arbiter #(.ADDR_W(3), .DATA_W(16), .MAX_LOCK(4)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_stall(a_stall), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_lock(b_lock),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read single-port memory.
  always @(posedge clk) begin
    if (mem_en && mem_we)  ram[mem_addr] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= ram[mem_addr];
  end

  // Response scoreboard for port A.
  always @(negedge clk) begin
    #2;
    n_tests++;
    if (a_rvalid === 1'b1) begin
      if (aq.size() == 0) begin
        n_fail++;
        $display("FAIL a_rsp_unexpected: got rvalid=1 rdata=%h want rvalid=0 (cycle %0d)", a_rdata, cyc);
      end else begin
        a_e = aq.pop_front();
        if (a_rdata !== a_e.data || a_e.due != cyc) begin
          n_fail++;
          $display("FAIL a_rsp_data: got %h at cycle %0d want %h at cycle %0d", a_rdata, cyc, a_e.data, a_e.due);
        end
      end
    end else if (aq.size() > 0 && aq[0].due <= cyc) begin
      a_e = aq.pop_front();
      n_fail++;
      $display("FAIL a_rsp_missing: got rvalid=%b want rvalid=1 rdata=%h (cycle %0d)", a_rvalid, a_e.data, cyc);
    end else if (a_rdata !== 16'h0) begin
      n_fail++;
      $display("FAIL a_rdata_idle: got %h want 0000", a_rdata);
    end
  end

  // Response scoreboard for port B.
  always @(negedge clk) begin
    #2;
    n_tests++;
    if (b_rvalid === 1'b1) begin
      if (bq.size() == 0) begin
        n_fail++;
        $display("FAIL b_rsp_unexpected: got rvalid=1 rdata=%h want rvalid=0 (cycle %0d)", b_rdata, cyc);
      end else begin
        b_e = bq.pop_front();
        if (b_rdata !== b_e.data || b_e.due != cyc) begin
          n_fail++;
          $display("FAIL b_rsp_data: got %h at cycle %0d want %h at cycle %0d", b_rdata, cyc, b_e.data, b_e.due);
        end
      end
    end else if (bq.size() > 0 && bq[0].due <= cyc) begin
      b_e = bq.pop_front();
      n_fail++;
      $display("FAIL b_rsp_missing: got rvalid=%b want rvalid=1 rdata=%h (cycle %0d)", b_rvalid, b_e.data, cyc);
    end else if (b_rdata !== 16'h0) begin
      n_fail++;
      $display("FAIL b_rdata_idle: got %h want 0000", b_rdata);
    end
  end

  // Apply one cycle of inputs at the falling edge, then let outputs settle.
  task automatic drive(input logic rst,
                       input logic ar, input logic awe, input logic [2:0] aad, input logic [15:0] awd,
                       input logic br, input logic bwe, input logic [2:0] bad, input logic [15:0] bwd,
                       input logic bl);
    @(negedge clk);
    reset = rst;
    a_req = ar; a_we = awe; a_addr = aad; a_wdata = awd;
    b_req = br; b_we = bwe; b_addr = bad; b_wdata = bwd; b_lock = bl;
    #1;
  endtask

  task automatic idle(input logic rst);
    drive(rst, 1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 3'd0, 16'h0, 1'b0);
  endtask

  task automatic test_reset();
    idle(1'b1);
    idle(1'b1);
    drive(1'b1, 1'b1, 1'b0, 3'd5, 16'h0, 1'b1, 1'b1, 3'd2, 16'hFFFF, 1'b0);
    n_tests++;
    if ({a_gnt, b_gnt, a_stall} !== 3'b000) begin
      n_fail++; $display("FAIL reset_gnt_forced: got a_gnt,b_gnt,a_stall=%b want 000", {a_gnt, b_gnt, a_stall});
    end
    n_tests++;
    if ({mem_en, mem_we} !== 2'b00) begin
      n_fail++; $display("FAIL reset_mem_forced: got en,we=%b want 00", {mem_en, mem_we});
    end
    idle(1'b0);
    n_tests++;
    if ({a_gnt, b_gnt, a_stall, a_rvalid, b_rvalid, mem_en, mem_we} !== 7'b0) begin
      n_fail++; $display("FAIL post_reset_ctrl: got %b want 0000000", {a_gnt, b_gnt, a_stall, a_rvalid, b_rvalid, mem_en, mem_we});
    end
    n_tests++;
    if ({a_rdata, b_rdata, mem_addr, mem_wdata} !== 51'b0) begin
      n_fail++; $display("FAIL post_reset_data: got a_rdata=%h b_rdata=%h addr=%0d wdata=%h want all 0", a_rdata, b_rdata, mem_addr, mem_wdata);
    end
    drive(1'b0, 1'b1, 1'b0, 3'd5, 16'h0, 1'b0, 1'b0, 3'd0, 16'h0, 1'b0);
    n_tests++;
    if ({a_gnt, a_stall, b_gnt} !== 3'b100) begin
      n_fail++; $display("FAIL first_read_gnt: got a_gnt,a_stall,b_gnt=%b want 100", {a_gnt, a_stall, b_gnt});
    end
    n_tests++;
    if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 3'd5}) begin
      n_fail++; $display("FAIL first_read_mem: got en=%b we=%b addr=%0d want en=1 we=0 addr=5", mem_en, mem_we, mem_addr);
    end
    aq.push_back('{ref_mem[5], cyc + 1});
    idle(1'b0);
  endtask

  task automatic test_round_robin();
    logic       exp_a;
    logic [2:0] exp_addr;
    // Lone B write leaves B as the most recent winner.
    drive(1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 1'b1, 1'b1, 3'd7, 16'h5555, 1'b0);
    n_tests++;
    if (b_gnt !== 1'b1 || mem_we !== 1'b1) begin
      n_fail++; $display("FAIL rr_setup_write: got b_gnt=%b mem_we=%b want 1 1", b_gnt, mem_we);
    end
    ref_mem[7] = 16'h5555;
    for (int i = 0; i < 4; i++) begin
      exp_a    = (i % 2 == 0);
      exp_addr = exp_a ? 3'd1 : 3'd3;
      drive(1'b0, 1'b1, 1'b0, 3'd1, 16'h0, 1'b1, 1'b0, 3'd3, 16'h0, 1'b0);
      n_tests++;
      if ({a_gnt, b_gnt} !== {exp_a, ~exp_a}) begin
        n_fail++; $display("FAIL rr_gnt[%0d]: got a,b=%b want %b", i, {a_gnt, b_gnt}, {exp_a, ~exp_a});
      end
      n_tests++;
      if (a_stall !== ~exp_a) begin
        n_fail++; $display("FAIL rr_stall[%0d]: got %b want %b", i, a_stall, ~exp_a);
      end
      n_tests++;
      if (mem_addr !== exp_addr) begin
        n_fail++; $display("FAIL rr_addr[%0d]: got %0d want %0d", i, mem_addr, exp_addr);
      end
      if (exp_a) aq.push_back('{ref_mem[1], cyc + 1});
      else       bq.push_back('{ref_mem[3], cyc + 1});
    end
    idle(1'b0);
  endtask

  task automatic test_write_then_read();
    drive(1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 1'b1, 1'b1, 3'd2, 16'hBEEF, 1'b0);
    n_tests++;
    if ({b_gnt, mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 1'b1, 3'd2, 16'hBEEF}) begin
      n_fail++; $display("FAIL wr_strobe: got gnt=%b en=%b we=%b addr=%0d wdata=%h want 1 1 1 2 beef", b_gnt, mem_en, mem_we, mem_addr, mem_wdata);
    end
    ref_mem[2] = 16'hBEEF;
    drive(1'b0, 1'b1, 1'b0, 3'd2, 16'h0, 1'b0, 1'b0, 3'd0, 16'h0, 1'b0);
    n_tests++;
    if ({a_gnt, mem_we, mem_wdata} !== {1'b1, 1'b0, 16'h0}) begin
      n_fail++; $display("FAIL rd_after_wr: got a_gnt=%b we=%b wdata=%h want 1 0 0000", a_gnt, mem_we, mem_wdata);
    end
    aq.push_back('{ref_mem[2], cyc + 1});
    idle(1'b0);
  endtask

  task automatic test_lock();
    logic [5:0] exp_b_seq;
`ifdef DMEM_ARB_LOCK_EN
    exp_b_seq = 6'b101111;
`else
    exp_b_seq = 6'b010101;
`endif
    // Lone A read leaves A as the most recent winner.
    drive(1'b0, 1'b1, 1'b0, 3'd4, 16'h0, 1'b0, 1'b0, 3'd0, 16'h0, 1'b0);
    n_tests++;
    if (a_gnt !== 1'b1) begin
      n_fail++; $display("FAIL lock_setup: got a_gnt=%b want 1", a_gnt);
    end
    aq.push_back('{ref_mem[4], cyc + 1});
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b1, 1'b0, 3'd0, 16'h0, 1'b1, 1'b0, 3'd6, 16'h0, 1'b1);
      n_tests++;
      if ({a_gnt, b_gnt} !== {~exp_b_seq[i], exp_b_seq[i]}) begin
        n_fail++; $display("FAIL lock_gnt[%0d]: got a,b=%b want %b", i, {a_gnt, b_gnt}, {~exp_b_seq[i], exp_b_seq[i]});
      end
      n_tests++;
      if (a_stall !== exp_b_seq[i]) begin
        n_fail++; $display("FAIL lock_stall[%0d]: got %b want %b", i, a_stall, exp_b_seq[i]);
      end
      if (exp_b_seq[i]) bq.push_back('{ref_mem[6], cyc + 1});
      else              aq.push_back('{ref_mem[0], cyc + 1});
    end
    idle(1'b0);
  endtask

  task automatic test_reset_drop();
    drive(1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 1'b1, 1'b0, 3'd3, 16'h0, 1'b0);
    n_tests++;
    if (b_gnt !== 1'b1) begin
      n_fail++; $display("FAIL drop_bgnt: got %b want 1", b_gnt);
    end
    idle(1'b1);
    n_tests++;
    if ({b_rvalid, b_rdata} !== 17'h0) begin
      n_fail++; $display("FAIL drop_rvalid: got rvalid=%b rdata=%h want 0 0000", b_rvalid, b_rdata);
    end
    drive(1'b1, 1'b1, 1'b0, 3'd5, 16'h0, 1'b1, 1'b0, 3'd6, 16'h0, 1'b0);
    n_tests++;
    if ({a_gnt, b_gnt, a_stall, mem_en} !== 4'b0000) begin
      n_fail++; $display("FAIL drop_reset_force: got %b want 0000", {a_gnt, b_gnt, a_stall, mem_en});
    end
    drive(1'b0, 1'b1, 1'b0, 3'd5, 16'h0, 1'b1, 1'b0, 3'd6, 16'h0, 1'b0);
    n_tests++;
    if ({a_gnt, b_gnt, a_stall} !== 3'b100) begin
      n_fail++; $display("FAIL post_reset_contend: got a,b,stall=%b want 100", {a_gnt, b_gnt, a_stall});
    end
    aq.push_back('{ref_mem[5], cyc + 1});
    drive(1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 1'b1, 1'b0, 3'd6, 16'h0, 1'b0);
    n_tests++;
    if ({a_gnt, b_gnt} !== 2'b01) begin
      n_fail++; $display("FAIL post_reset_b: got a,b=%b want 01", {a_gnt, b_gnt});
    end
    bq.push_back('{ref_mem[6], cyc + 1});
    idle(1'b0);
  endtask

  task automatic test_stream();
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, 1'b0, 3'(i), 16'h0, 1'b0, 1'b0, 3'd0, 16'h0, 1'b0);
      n_tests++;
      if ({a_gnt, a_stall, mem_addr} !== {1'b1, 1'b0, 3'(i)}) begin
        n_fail++; $display("FAIL stream[%0d]: got gnt=%b stall=%b addr=%0d want 1 0 %0d", i, a_gnt, a_stall, mem_addr, i);
      end
      aq.push_back('{ref_mem[i], cyc + 1});
    end
    idle(1'b0);
  endtask

  task automatic test_drain();
    idle(1'b0);
    idle(1'b0);
    idle(1'b0);
    #3;
    n_tests++;
    if (aq.size() != 0 || bq.size() != 0) begin
      n_fail++; $display("FAIL drain: got %0d/%0d responses outstanding want 0/0", aq.size(), bq.size());
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_write_then_read();
    test_lock();
    test_reset_drop();
    test_stream();
    test_drain();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
